// File: rtl/dx_operand_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dx_operand_issue_pkg
// Brief    : ISA field layout, opcode/ALU constants and instruction decoder.
// Revision : 1.0
// ============================================================================
package dx_operand_issue_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;

    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int FIELD_W   = 5;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLL = 5'd4;
    localparam logic [4:0] ALU_SRA = 5'd5;

    typedef struct packed {
        logic is_rtype;
        logic use_rs;
        logic use_rt;
        logic use_rd;
        logic imm_b;
        logic wb;
        logic is_load;
        logic is_store;
    } dec_t;

    // Unknown opcodes decode to all-zero, which issues as a NOP.
    function automatic dec_t decode(input logic [4:0] opcode, input logic [4:0] aluop);
        dec_t d;
        d = '0;
        case (opcode)
            OP_RTYPE: begin
                d.is_rtype = 1'b1;
                d.use_rs   = 1'b1;
                d.use_rt   = (aluop != ALU_SLL) && (aluop != ALU_SRA);
                d.wb       = 1'b1;
            end
            OP_ADDI: begin
                d.use_rs = 1'b1;
                d.imm_b  = 1'b1;
                d.wb     = 1'b1;
            end
            OP_LW: begin
                d.use_rs  = 1'b1;
                d.imm_b   = 1'b1;
                d.wb      = 1'b1;
                d.is_load = 1'b1;
            end
            OP_SW: begin
                d.use_rs   = 1'b1;
                d.imm_b    = 1'b1;
                d.use_rd   = 1'b1;
                d.is_store = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module   : operand_bypass
// Brief    : Source operand priority mux: r0 > byp1 > byp2 > register file.
// Revision : 1.0
// ============================================================================
module operand_bypass #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              byp1_valid,
    input  logic [REG_AW-1:0] byp1_rd,
    input  logic [DATA_W-1:0] byp1_data,
    input  logic              byp2_valid,
    input  logic [REG_AW-1:0] byp2_rd,
    input  logic [DATA_W-1:0] byp2_data,
    output logic [DATA_W-1:0] value
);

    always_comb begin
        value = rf_data;
        if (src == '0) begin
            value = '0;
        end else if (byp1_valid && (byp1_rd == src)) begin
            value = byp1_data;
        end else if (byp2_valid && (byp2_rd == src)) begin
            value = byp2_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dx_operand_issue.sv
`default_nettype none
// ============================================================================
// Module   : dx_operand_issue
// Brief    : Decode/issue stage: operand bypass, load-use stall, ID/EX register.
// Revision : 1.0
// ============================================================================
module dx_operand_issue
    import dx_operand_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 17
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_insn,
    input  logic              flush,
    output logic [REG_AW-1:0] ctrl_readRegA,
    output logic [REG_AW-1:0] ctrl_readRegB,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB,
    input  logic              byp1_valid,
    input  logic [REG_AW-1:0] byp1_rd,
    input  logic [DATA_W-1:0] byp1_data,
    input  logic              byp2_valid,
    input  logic [REG_AW-1:0] byp2_rd,
    input  logic [DATA_W-1:0] byp2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_operandA,
    output logic [DATA_W-1:0] data_operandB,
    output logic [4:0]        ctrl_ALUopcode,
    output logic [4:0]        ctrl_shiftamt,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic [DATA_W-1:0] out_store_data
);

    logic [4:0]        w_opcode;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [4:0]        w_shamt;
    logic [4:0]        w_aluop;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_imm_ext;
    dec_t              w_dec;

    assign w_opcode  = in_insn[OPC_LSB +: FIELD_W];
    assign w_rd      = in_insn[RD_LSB +: REG_AW];
    assign w_rs      = in_insn[RS_LSB +: REG_AW];
    assign w_rt      = in_insn[RT_LSB +: REG_AW];
    assign w_shamt   = in_insn[SHAMT_LSB +: FIELD_W];
    assign w_aluop   = in_insn[ALUOP_LSB +: FIELD_W];
    assign w_imm     = in_insn[IMM_W-1:0];
    assign w_imm_ext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_dec     = decode(w_opcode, w_aluop);

    // Port B carries the store data register for sw, whose B operand is the immediate.
    assign ctrl_readRegA = w_rs;
    assign ctrl_readRegB = w_dec.is_store ? w_rd : w_rt;

    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;
    logic [DATA_W-1:0] w_val_st;

    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_a (
        .src(w_rs), .rf_data(data_readRegA),
        .byp1_valid(byp1_valid), .byp1_rd(byp1_rd), .byp1_data(byp1_data),
        .byp2_valid(byp2_valid), .byp2_rd(byp2_rd), .byp2_data(byp2_data),
        .value(w_val_a)
    );

    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_b (
        .src(w_rt), .rf_data(data_readRegB),
        .byp1_valid(byp1_valid), .byp1_rd(byp1_rd), .byp1_data(byp1_data),
        .byp2_valid(byp2_valid), .byp2_rd(byp2_rd), .byp2_data(byp2_data),
        .value(w_val_b)
    );

    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_st (
        .src(w_rd), .rf_data(data_readRegB),
        .byp1_valid(byp1_valid), .byp1_rd(byp1_rd), .byp1_data(byp1_data),
        .byp2_valid(byp2_valid), .byp2_rd(byp2_rd), .byp2_data(byp2_data),
        .value(w_val_st)
    );

    logic w_src_hit;
    logic w_hazard;
    logic w_advance;
    logic w_accept;

    assign w_src_hit = (w_dec.use_rs && (w_rs == out_rd)) ||
                       (w_dec.use_rt && (w_rt == out_rd)) ||
                       (w_dec.use_rd && (w_rd == out_rd));
    assign w_hazard  = out_valid && out_is_load && (out_rd != '0) && w_src_hit;
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = flush | (!w_hazard & w_advance);
    assign w_accept  = in_valid && !w_hazard && !flush;

    logic [DATA_W-1:0] w_nxt_a;
    logic [DATA_W-1:0] w_nxt_b;
    logic [DATA_W-1:0] w_nxt_st;
    logic [4:0]        w_nxt_op;
    logic [4:0]        w_nxt_sh;
    logic [REG_AW-1:0] w_nxt_rd;

    always_comb begin
        w_nxt_a  = w_dec.use_rs ? w_val_a : '0;
        w_nxt_b  = '0;
        if (w_dec.imm_b) begin
            w_nxt_b = w_imm_ext;
        end else if (w_dec.use_rt) begin
            w_nxt_b = w_val_b;
        end
        w_nxt_st = w_dec.is_store ? w_val_st : '0;
        w_nxt_op = w_dec.is_rtype ? w_aluop : ALU_ADD;
        w_nxt_sh = w_dec.is_rtype ? w_shamt : 5'd0;
        w_nxt_rd = w_dec.wb ? w_rd : '0;
    end

    // A stalled or empty slot leaves payload untouched; only out_valid drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            data_operandA  <= '0;
            data_operandB  <= '0;
            ctrl_ALUopcode <= '0;
            ctrl_shiftamt  <= '0;
            out_rd         <= '0;
            out_is_load    <= 1'b0;
            out_is_store   <= 1'b0;
            out_store_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_advance) begin
            out_valid <= w_accept;
            if (w_accept) begin
                data_operandA  <= w_nxt_a;
                data_operandB  <= w_nxt_b;
                ctrl_ALUopcode <= w_nxt_op;
                ctrl_shiftamt  <= w_nxt_sh;
                out_rd         <= w_nxt_rd;
                out_is_load    <= w_dec.is_load;
                out_is_store   <= w_dec.is_store;
                out_store_data <= w_nxt_st;
            end
        end
    end

endmodule
`default_nettype wire
